// File: rtl/game_pkg.sv
// Shared definitions for the score controller: state encoding and score limits.
package game_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_FLASH = 2'd2;
  localparam logic [1:0] ST_WON   = 2'd3;

  localparam int         MAX_DIGIT   = 9;
  localparam logic [1:0] PENDING_MAX = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_PLAY  = ST_PLAY,
    S_FLASH = ST_FLASH,
    S_WON   = ST_WON
  } state_e;

endpackage

// File: rtl/score_blink.sv
// Frame-tick blink divider: flips its level every BLINK_HALF enabled frame ticks.
module score_blink #(
  parameter int BLINK_HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic frame_tick,
  input  logic enable,
  output logic toggle
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          toggle_q, toggle_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    toggle_d    = toggle_q;
    if (clear) begin
      blink_cnt_d = '0;
      toggle_d    = 1'b0;
    end else if (enable && frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        blink_cnt_d = '0;
        toggle_d    = ~toggle_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      toggle_q    <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      toggle_q    <= toggle_d;
    end
  end

  assign toggle = toggle_q;

endmodule

// File: rtl/score_ctrl.sv
// Score controller: buffers item events and applies them to the digit at frame
// boundaries, flashing after each increment and blinking once the game is won.
module score_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_HALF   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       point,
  input  logic       frame_tick,
  output logic [3:0] score,
  output logic       digit_visible,
  output logic       win,
  output logic       lost_point
);

  localparam int FW      = $clog2(FLASH_FRAMES + 1);
  localparam int WIN_EFF = (WIN_SCORE > MAX_DIGIT) ? MAX_DIGIT : WIN_SCORE;

  state_e         state_q, state_d;
  logic [3:0]     score_q, score_d;
  logic [1:0]     pending_q, pending_d;
  logic [FW-1:0]  flash_cnt_q, flash_cnt_d;
  logic           win_q, win_d;
  logic           lost_q, lost_d;
  logic           vis_base_q, vis_base_d;
  logic           blink_clear;
  logic           blink_en;
  logic           blink_level;

  // Point accounting shared by PLAY and FLASH when no increment consumes a slot.
  logic [1:0] pending_pt;
  logic       lost_pt;
  always_comb begin
    pending_pt = pending_q;
    lost_pt    = lost_q;
    if (point) begin
      if (pending_q < PENDING_MAX) pending_pt = pending_q + 2'd1;
      else                         lost_pt    = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    pending_d   = pending_q;
    flash_cnt_d = flash_cnt_q;
    win_d       = win_q;
    lost_d      = lost_q;
    vis_base_d  = vis_base_q;
    blink_clear = 1'b0;
    if (game_start) begin
      state_d     = S_PLAY;
      score_d     = '0;
      pending_d   = '0;
      flash_cnt_d = '0;
      win_d       = 1'b0;
      lost_d      = 1'b0;
      vis_base_d  = 1'b1;
      blink_clear = 1'b1;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (frame_tick && pending_q != 2'd0) begin
            score_d     = score_q + 4'd1;
            pending_d   = pending_q - 2'd1 + {1'b0, point};
            vis_base_d  = 1'b0;
            blink_clear = 1'b1;
            if (score_q + 4'd1 == 4'(WIN_EFF)) begin
              state_d = S_WON;
              win_d   = 1'b1;
            end else begin
              state_d     = S_FLASH;
              flash_cnt_d = FW'(FLASH_FRAMES);
            end
          end else begin
            pending_d = pending_pt;
            lost_d    = lost_pt;
          end
        end
        S_FLASH: begin
          pending_d = pending_pt;
          lost_d    = lost_pt;
          if (frame_tick) begin
            flash_cnt_d = flash_cnt_q - 1'b1;
            if (flash_cnt_q <= FW'(1)) begin
              flash_cnt_d = '0;
              state_d     = S_PLAY;
              vis_base_d  = 1'b1;
              blink_clear = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign blink_en = (state_q == S_FLASH) || (state_q == S_WON);

  score_blink #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (blink_clear),
    .frame_tick(frame_tick),
    .enable    (blink_en),
    .toggle    (blink_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      pending_q   <= '0;
      flash_cnt_q <= '0;
      win_q       <= 1'b0;
      lost_q      <= 1'b0;
      vis_base_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      pending_q   <= pending_d;
      flash_cnt_q <= flash_cnt_d;
      win_q       <= win_d;
      lost_q      <= lost_d;
      vis_base_q  <= vis_base_d;
    end
  end

  // The blink level is cleared whenever the base changes, so the XOR of two flops
  // yields visible=1 outside blinking and starts each blink phase hidden.
  assign digit_visible = vis_base_q ^ blink_level;
  assign score         = score_q;
  assign win           = win_q;
  assign lost_point    = lost_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed self-checking bench for score_ctrl (default build plus a WIN_SCORE=2 build).
module tb_score_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_start, point, frame_tick;
  logic [3:0] score, score_w;
  logic       digit_visible, digit_visible_w;
  logic       win, win_w;
  logic       lost_point, lost_point_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_start   (game_start),
    .point        (point),
    .frame_tick   (frame_tick),
    .score        (score),
    .digit_visible(digit_visible),
    .win          (win),
    .lost_point   (lost_point)
  );

  score_ctrl #(.WIN_SCORE(2)) dut_w (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_start   (game_start),
    .point        (point),
    .frame_tick   (frame_tick),
    .score        (score_w),
    .digit_visible(digit_visible_w),
    .win          (win_w),
    .lost_point   (lost_point_w)
  );

  // Inputs are applied 1ns after an edge, sampled on the next edge, checked 1ns later.
  task automatic cyc(input logic gs, input logic pt, input logic ft);
    game_start = gs;
    point      = pt;
    frame_tick = ft;
    @(posedge clk);
    #1;
    game_start = 1'b0;
    point      = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (score !== 4'd0)       begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if (digit_visible !== 1'b1) begin errors++; $display("FAIL reset_visible got=%b exp=1", digit_visible); end
    checks++; if (win !== 1'b0)         begin errors++; $display("FAIL reset_win got=%b exp=0", win); end
    checks++; if (lost_point !== 1'b0)  begin errors++; $display("FAIL reset_lost got=%b exp=0", lost_point); end
    $display("test_reset: score=%0d vis=%b win=%b lost=%b", score, digit_visible, win, lost_point);
  endtask

  task automatic test_single_point();
    logic exp_vis;
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    checks++; if (score !== 4'd1)         begin errors++; $display("FAIL sp_score got=%0d exp=1", score); end
    checks++; if (digit_visible !== 1'b0) begin errors++; $display("FAIL sp_vis_enter got=%b exp=0", digit_visible); end
    checks++; if (dut.state_q !== S_FLASH) begin errors++; $display("FAIL sp_state_flash got=%0d exp=%0d", dut.state_q, S_FLASH); end
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 0, 1);
      exp_vis = (i == 30) ? 1'b1 : 1'(((i / 8) % 2));
      checks++;
      if (digit_visible !== exp_vis) begin
        errors++; $display("FAIL sp_vis_tick%0d got=%b exp=%b", i, digit_visible, exp_vis);
      end
    end
    checks++; if (dut.state_q !== S_PLAY) begin errors++; $display("FAIL sp_state_play got=%0d exp=%0d", dut.state_q, S_PLAY); end
    checks++; if (score !== 4'd1)         begin errors++; $display("FAIL sp_score_hold got=%0d exp=1", score); end
    $display("test_single_point: score=%0d vis=%b", score, digit_visible);
  endtask

  task automatic test_saturate();
    cyc(1, 0, 0);
    repeat (5) cyc(0, 1, 0);
    checks++; if (dut.pending_q !== 2'd3) begin errors++; $display("FAIL sat_pending got=%0d exp=3", dut.pending_q); end
    checks++; if (lost_point !== 1'b1)    begin errors++; $display("FAIL sat_lost got=%b exp=1", lost_point); end
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 1);
      checks++;
      if (score !== 4'(k)) begin errors++; $display("FAIL sat_score_inc%0d got=%0d exp=%0d", k, score, k); end
      repeat (30) cyc(0, 0, 1);
    end
    cyc(0, 0, 1);
    checks++; if (score !== 4'd3)      begin errors++; $display("FAIL sat_score_final got=%0d exp=3", score); end
    checks++; if (lost_point !== 1'b1) begin errors++; $display("FAIL sat_lost_sticky got=%b exp=1", lost_point); end
    $display("test_saturate: score=%0d lost=%b", score, lost_point);
  endtask

  task automatic test_coincident();
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    checks++; if (score !== 4'd1)         begin errors++; $display("FAIL coin_score got=%0d exp=1", score); end
    checks++; if (dut.pending_q !== 2'd1) begin errors++; $display("FAIL coin_pending got=%0d exp=1", dut.pending_q); end
    checks++; if (lost_point !== 1'b0)    begin errors++; $display("FAIL coin_lost got=%b exp=0", lost_point); end
    $display("test_coincident: score=%0d pending=%0d", score, dut.pending_q);
  endtask

  task automatic test_win();
    logic exp_vis;
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    checks++; if (score_w !== 4'd1) begin errors++; $display("FAIL win_score1 got=%0d exp=1", score_w); end
    checks++; if (win_w !== 1'b0)   begin errors++; $display("FAIL win_early got=%b exp=0", win_w); end
    repeat (30) cyc(0, 0, 1);
    cyc(0, 0, 1);
    checks++; if (score_w !== 4'd2)         begin errors++; $display("FAIL win_score2 got=%0d exp=2", score_w); end
    checks++; if (win_w !== 1'b1)           begin errors++; $display("FAIL win_level got=%b exp=1", win_w); end
    checks++; if (digit_visible_w !== 1'b0) begin errors++; $display("FAIL win_vis_enter got=%b exp=0", digit_visible_w); end
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 1);
      exp_vis = 1'(((i / 8) % 2));
      checks++;
      if (digit_visible_w !== exp_vis) begin
        errors++; $display("FAIL win_vis_tick%0d got=%b exp=%b", i, digit_visible_w, exp_vis);
      end
    end
    checks++; if (score_w !== 4'd2) begin errors++; $display("FAIL win_score_hold got=%0d exp=2", score_w); end
    checks++; if (win_w !== 1'b1)   begin errors++; $display("FAIL win_hold got=%b exp=1", win_w); end
    $display("test_win: score=%0d win=%b vis=%b", score_w, win_w, digit_visible_w);
  endtask

  task automatic test_start_priority();
    cyc(1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 1, 0);
      cyc(0, 0, 1);
      if (k < 4) repeat (30) cyc(0, 0, 1);
    end
    repeat (3) cyc(0, 0, 1);
    cyc(0, 1, 0);
    checks++; if (score !== 4'd4)          begin errors++; $display("FAIL gs_pre_score got=%0d exp=4", score); end
    checks++; if (dut.state_q !== S_FLASH) begin errors++; $display("FAIL gs_pre_state got=%0d exp=%0d", dut.state_q, S_FLASH); end
    cyc(1, 1, 1);
    checks++; if (score !== 4'd0)         begin errors++; $display("FAIL gs_score got=%0d exp=0", score); end
    checks++; if (dut.pending_q !== 2'd0) begin errors++; $display("FAIL gs_pending got=%0d exp=0", dut.pending_q); end
    checks++; if (digit_visible !== 1'b1) begin errors++; $display("FAIL gs_vis got=%b exp=1", digit_visible); end
    checks++; if (dut.state_q !== S_PLAY) begin errors++; $display("FAIL gs_state got=%0d exp=%0d", dut.state_q, S_PLAY); end
    $display("test_start_priority: score=%0d vis=%b", score, digit_visible);
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 1);
    checks++; if (digit_visible !== 1'b0) begin errors++; $display("FAIL ar_pre_vis got=%b exp=0", digit_visible); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (score !== 4'd0)          begin errors++; $display("FAIL ar_score got=%0d exp=0", score); end
    checks++; if (digit_visible !== 1'b1)  begin errors++; $display("FAIL ar_vis got=%b exp=1", digit_visible); end
    checks++; if (win !== 1'b0 || lost_point !== 1'b0) begin errors++; $display("FAIL ar_flags got=%b%b exp=00", win, lost_point); end
    checks++; if (dut.state_q !== S_IDLE)  begin errors++; $display("FAIL ar_state got=%0d exp=%0d", dut.state_q, S_IDLE); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(0, 1, 0);
    cyc(0, 1, 1);
    checks++; if (score !== 4'd0)         begin errors++; $display("FAIL idle_score got=%0d exp=0", score); end
    checks++; if (digit_visible !== 1'b1) begin errors++; $display("FAIL idle_vis got=%b exp=1", digit_visible); end
    checks++; if (dut.pending_q !== 2'd0) begin errors++; $display("FAIL idle_pending got=%0d exp=0", dut.pending_q); end
    $display("test_async_reset: score=%0d vis=%b", score, digit_visible);
  endtask

  initial begin
    rst_n      = 1'b0;
    game_start = 1'b0;
    point      = 1'b0;
    frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_single_point();
    test_saturate();
    test_coincident();
    test_win();
    test_start_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
